// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_stall_ctrl : load-use / branch-flush / memory-wait stall sequencer
// Rev 1.0
// ============================================================================
module hazard_stall_ctrl #(
  parameter int LU_CYCLES    = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifid_valid,
  input  logic [4:0]       ifid_rs_addr,
  input  logic [4:0]       ifid_rt_addr,
  input  logic             idex_mem_r,
  input  logic [4:0]       idex_rt_addr,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_w_en,
  output logic             ifid_w_en,
  output logic             idex_w_en,
  output logic             exmem_w_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  localparam logic [2:0] c_lu_rem  = 3'(LU_CYCLES - 1);
  localparam logic [2:0] c_fl_rem  = 3'(FLUSH_CYCLES - 1);
  localparam state_t     c_lu_next = (LU_CYCLES > 1) ? LU_STALL : RUN;
  localparam state_t     c_fl_next = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  state_t           state_q, state_d;
  state_t           ret_state_q, ret_state_d;
  logic [2:0]       rem_q, rem_d;
  logic [2:0]       ret_rem_q, ret_rem_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic   w_lu;
  logic   w_mw;
  logic   w_freeze;
  state_t w_eval_state;
  logic [2:0] w_eval_rem;

  assign w_lu = idex_mem_r && (idex_rt_addr != 5'd0) && ifid_valid &&
                ((idex_rt_addr == ifid_rs_addr) || (idex_rt_addr == ifid_rt_addr));
  assign w_mw = dmem_req && !dmem_ready;

  // A release from MEM_WAIT replays the interrupted state with its saved count.
  assign w_eval_state = (state_q == MEM_WAIT) ? ret_state_q : state_q;
  assign w_eval_rem   = (state_q == MEM_WAIT) ? ret_rem_q   : rem_q;
  assign w_freeze     = (state_q == MEM_WAIT) ? !dmem_ready : w_mw;

  always_comb begin
    pc_w_en     = 1'b1;
    ifid_w_en   = 1'b1;
    idex_w_en   = 1'b1;
    exmem_w_en  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = state_q;
    rem_d       = rem_q;
    ret_state_d = ret_state_q;
    ret_rem_d   = ret_rem_q;

    if (rst) begin
      pc_w_en     = 1'b0;
      ifid_w_en   = 1'b0;
      idex_w_en   = 1'b0;
      exmem_w_en  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_freeze) begin
      pc_w_en    = 1'b0;
      ifid_w_en  = 1'b0;
      idex_w_en  = 1'b0;
      exmem_w_en = 1'b0;
      if (state_q != MEM_WAIT) begin
        ret_state_d = state_q;
        ret_rem_d   = rem_q;
        state_d     = MEM_WAIT;
      end
    end else begin
      state_d = w_eval_state;
      rem_d   = w_eval_rem;
      case (w_eval_state)
        RUN: begin
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = c_fl_next;
            rem_d       = c_fl_rem;
          end else if (w_lu) begin
            pc_w_en     = 1'b0;
            ifid_w_en   = 1'b0;
            idex_bubble = 1'b1;
            state_d     = c_lu_next;
            rem_d       = c_lu_rem;
          end
        end
        LU_STALL: begin
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = c_fl_next;
            rem_d       = c_fl_rem;
          end else begin
            pc_w_en     = 1'b0;
            ifid_w_en   = 1'b0;
            idex_bubble = 1'b1;
            rem_d       = w_eval_rem - 3'd1;
            state_d     = (w_eval_rem == 3'd1) ? RUN : LU_STALL;
          end
        end
        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (branch_taken) begin
            state_d = c_fl_next;
            rem_d   = c_fl_rem;
          end else begin
            rem_d   = w_eval_rem - 3'd1;
            state_d = (w_eval_rem == 3'd1) ? RUN : FLUSH;
          end
        end
        default: begin
          state_d = RUN;
          rem_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      rem_q       <= 3'd0;
      ret_state_q <= RUN;
      ret_rem_q   <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      ret_state_q <= ret_state_d;
      ret_rem_q   <= ret_rem_d;
      if (!pc_w_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_stall_ctrl : directed vector bench over three parameterisations
// Rev 1.0
// ============================================================================
module tb_hazard_stall_ctrl;

  localparam int I_IDLE   = 0;
  localparam int I_LU     = 1;
  localparam int I_ZERO   = 2;
  localparam int I_BR     = 3;
  localparam int I_MW     = 4;
  localparam int I_RDY    = 5;
  localparam int I_ALL    = 6;
  localparam int I_ALLRDY = 7;
  localparam int I_RST    = 8;
  localparam int I_LURT   = 9;
  localparam int I_NOVAL  = 10;

  // {pc, ifid, idex, exmem, flush, bubble}
  localparam logic [5:0] RUNC = 6'b111100;
  localparam logic [5:0] LUB  = 6'b001101;
  localparam logic [5:0] FLB  = 6'b111111;
  localparam logic [5:0] FRZ  = 6'b000000;
  localparam logic [5:0] RSTC = 6'b000011;

  localparam int NV = 28;

  logic       clk = 1'b0;
  logic       rst;
  logic       ifid_valid;
  logic [4:0] ifid_rs_addr, ifid_rt_addr, idex_rt_addr;
  logic       idex_mem_r, branch_taken, dmem_req, dmem_ready;

  logic        pc1, ifid1, idex1, exmem1, flush1, bub1;
  logic        pc2, ifid2, idex2, exmem2, flush2, bub2;
  logic        pc3, ifid3, idex3, exmem3, flush3, bub3;
  logic [15:0] cnt1, cnt2;
  logic [1:0]  cnt3;
  logic [1:0]  st1, st2, st3;
  logic [5:0]  ctl1, ctl2;

  assign ctl1 = {pc1, ifid1, idex1, exmem1, flush1, bub1};
  assign ctl2 = {pc2, ifid2, idex2, exmem2, flush2, bub2};

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.LU_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .ifid_valid(ifid_valid), .ifid_rs_addr(ifid_rs_addr),
    .ifid_rt_addr(ifid_rt_addr), .idex_mem_r(idex_mem_r), .idex_rt_addr(idex_rt_addr),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_w_en(pc1), .ifid_w_en(ifid1), .idex_w_en(idex1), .exmem_w_en(exmem1),
    .ifid_flush(flush1), .idex_bubble(bub1), .stall_cnt(cnt1), .state_o(st1));

  hazard_stall_ctrl #(.LU_CYCLES(2), .FLUSH_CYCLES(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .ifid_valid(ifid_valid), .ifid_rs_addr(ifid_rs_addr),
    .ifid_rt_addr(ifid_rt_addr), .idex_mem_r(idex_mem_r), .idex_rt_addr(idex_rt_addr),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_w_en(pc2), .ifid_w_en(ifid2), .idex_w_en(idex2), .exmem_w_en(exmem2),
    .ifid_flush(flush2), .idex_bubble(bub2), .stall_cnt(cnt2), .state_o(st2));

  hazard_stall_ctrl #(.LU_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .ifid_valid(ifid_valid), .ifid_rs_addr(ifid_rs_addr),
    .ifid_rt_addr(ifid_rt_addr), .idex_mem_r(idex_mem_r), .idex_rt_addr(idex_rt_addr),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_w_en(pc3), .ifid_w_en(ifid3), .idex_w_en(idex3), .exmem_w_en(exmem3),
    .ifid_flush(flush3), .idex_bubble(bub3), .stall_cnt(cnt3), .state_o(st3));

  typedef struct {
    int         kind;
    logic [5:0] c1;
    logic [1:0] s1;
    int         n1;
    logic [5:0] c2;
    logic [1:0] s2;
    int         n2;
    int         n3;
  } vec_t;

  vec_t vecs [NV];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int row, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  task automatic setv(input int i, input int kind,
                      input logic [5:0] c1, input logic [1:0] s1, input int n1,
                      input logic [5:0] c2, input logic [1:0] s2, input int n2,
                      input int n3);
    vecs[i].kind = kind;
    vecs[i].c1 = c1; vecs[i].s1 = s1; vecs[i].n1 = n1;
    vecs[i].c2 = c2; vecs[i].s2 = s2; vecs[i].n2 = n2;
    vecs[i].n3 = n3;
  endtask

  task automatic apply(input int kind);
    rst          = (kind == I_RST);
    ifid_valid   = (kind != I_NOVAL);
    ifid_rs_addr = (kind == I_ZERO) ? 5'd0 : (kind == I_LURT) ? 5'd7 : 5'd5;
    ifid_rt_addr = (kind == I_LURT) ? 5'd5 : 5'd6;
    idex_rt_addr = (kind == I_ZERO) ? 5'd0 : 5'd5;
    idex_mem_r   = (kind == I_LU) || (kind == I_ZERO) || (kind == I_ALL) ||
                   (kind == I_ALLRDY) || (kind == I_LURT) || (kind == I_NOVAL);
    branch_taken = (kind == I_BR) || (kind == I_ALL) || (kind == I_ALLRDY);
    dmem_req     = (kind == I_MW) || (kind == I_RDY) || (kind == I_ALL) || (kind == I_ALLRDY);
    dmem_ready   = (kind == I_RDY) || (kind == I_ALLRDY);
  endtask

  initial begin
    //      kind      dut1: ctl st cnt   dut2: ctl st cnt  dut3 cnt
    setv( 0, I_RST,    RSTC, 0, 0,  RSTC, 0,  0, 0);
    setv( 1, I_IDLE,   RUNC, 0, 0,  RUNC, 0,  0, 0);
    setv( 2, I_LU,     LUB,  0, 0,  LUB,  0,  0, 0);
    setv( 3, I_IDLE,   RUNC, 0, 1,  LUB,  1,  1, 1);
    setv( 4, I_IDLE,   RUNC, 0, 1,  RUNC, 0,  2, 1);
    setv( 5, I_ZERO,   RUNC, 0, 1,  RUNC, 0,  2, 1);
    setv( 6, I_BR,     FLB,  0, 1,  FLB,  0,  2, 1);
    setv( 7, I_IDLE,   RUNC, 0, 1,  FLB,  2,  2, 1);
    setv( 8, I_MW,     FRZ,  0, 1,  FRZ,  0,  2, 1);
    setv( 9, I_MW,     FRZ,  3, 2,  FRZ,  3,  3, 2);
    setv(10, I_MW,     FRZ,  3, 3,  FRZ,  3,  4, 3);
    setv(11, I_RDY,    RUNC, 3, 4,  RUNC, 3,  5, 3);
    setv(12, I_IDLE,   RUNC, 0, 4,  RUNC, 0,  5, 3);
    setv(13, I_ALL,    FRZ,  0, 4,  FRZ,  0,  5, 3);
    setv(14, I_ALLRDY, FLB,  3, 5,  FLB,  3,  6, 3);
    setv(15, I_IDLE,   RUNC, 0, 5,  FLB,  2,  6, 3);
    setv(16, I_LU,     LUB,  0, 5,  LUB,  0,  6, 3);
    setv(17, I_MW,     FRZ,  0, 6,  FRZ,  1,  7, 3);
    setv(18, I_RDY,    RUNC, 3, 7,  LUB,  3,  8, 3);
    setv(19, I_IDLE,   RUNC, 0, 7,  RUNC, 0,  9, 3);
    setv(20, I_LURT,   LUB,  0, 7,  LUB,  0,  9, 3);
    setv(21, I_BR,     FLB,  0, 8,  FLB,  1, 10, 3);
    setv(22, I_IDLE,   RUNC, 0, 8,  FLB,  2, 10, 3);
    setv(23, I_NOVAL,  RUNC, 0, 8,  RUNC, 0, 10, 3);
    setv(24, I_BR,     FLB,  0, 8,  FLB,  0, 10, 3);
    setv(25, I_BR,     FLB,  0, 8,  FLB,  2, 10, 3);
    setv(26, I_IDLE,   RUNC, 0, 8,  FLB,  2, 10, 3);
    setv(27, I_IDLE,   RUNC, 0, 8,  RUNC, 0, 10, 3);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].kind);
      @(negedge clk);
      chk("ctl1", i, int'(ctl1), int'(vecs[i].c1));
      chk("st1",  i, int'(st1),  int'(vecs[i].s1));
      chk("cnt1", i, int'(cnt1), vecs[i].n1);
      chk("ctl2", i, int'(ctl2), int'(vecs[i].c2));
      chk("st2",  i, int'(st2),  int'(vecs[i].s2));
      chk("cnt2", i, int'(cnt2), vecs[i].n2);
      chk("cnt3", i, int'(cnt3), vecs[i].n3);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset landing in the middle of a two-bubble load-use stall.
    apply(I_LU);
    @(negedge clk);
    chk("pre_ctl2", 100, int'(ctl2), int'(LUB));
    @(posedge clk);
    #2;
    chk("pre_st2", 101, int'(st2), 1);
    apply(I_RST);
    #1;
    chk("arst_st2",  102, int'(st2),  0);
    chk("arst_cnt2", 102, int'(cnt2), 0);
    chk("arst_cnt1", 102, int'(cnt1), 0);
    chk("arst_ctl2", 102, int'(ctl2), int'(RSTC));
    @(posedge clk);
    #1;
    chk("held_ctl2", 103, int'(ctl2), int'(RSTC));
    chk("held_st2",  103, int'(st2),  0);
    apply(I_IDLE);
    @(negedge clk);
    chk("post_ctl2", 104, int'(ctl2), int'(RUNC));
    chk("post_st2",  104, int'(st2),  0);
    chk("post_cnt2", 104, int'(cnt2), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post2_ctl2", 105, int'(ctl2), int'(RUNC));
    chk("post2_cnt2", 105, int'(cnt2), 0);

    // Five frozen cycles: the 2-bit counter pins at 3, the wide one reaches 5.
    @(posedge clk);
    #1;
    apply(I_MW);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_cnt3", 106, int'(cnt3), 3);
    chk("sat_cnt1", 106, int'(cnt1), 5);
    chk("sat_st1",  106, int'(st1),  3);
    apply(I_RDY);
    @(negedge clk);
    chk("rel_ctl1", 107, int'(ctl1), int'(RUNC));
    @(posedge clk);
    #1;
    apply(I_IDLE);
    @(negedge clk);
    chk("rel_st1",  108, int'(st1),  0);
    chk("rel_cnt1", 108, int'(cnt1), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
